pong_ball_ctrl: RTL and testbench
=================================

# pong_ball_ctrl

- Ball/rally controller for the FPGA ping-pong game.
- Consumes the one-cycle tick enable produced by the prescaler chain and moves a one-hot ball along an LED row, one step per tick.
- Resolves paddle hits and misses, keeps both scores, and ends the game at a fixed winning score.
- Sits between the prescaler output, the synchronized paddle buttons, and the LED/score display logic.

## Interface
- N_LEDS, 8, LED row length (≥4); bit 0 is the left end.
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 9, score that ends the game (< 2^SCORE_W).
- POINT_TICKS, 4, ticks the point indication is held.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle step enable from the prescaler; may be high on consecutive cycles.
- btn_l  in  1  left paddle level, already synchronized to clk.
- btn_r  in  1  right paddle level, already synchronized to clk.
- leds  out  N_LEDS  ball display.
- score_l  out  SCORE_W  left player score.
- score_r  out  SCORE_W  right player score.
- point  out  1  one-cycle pulse when either score increments.
- game_over  out  1  high while in OVER.

## Operation
- **Registered state:** state ∈ {IDLE, MOVE_R, MOVE_L, POINT, OVER}, pos (ball index), serve_side (L/R), hold counter, both scores, btn_l_q and btn_r_q (previous button levels).
- **Press detection:** press_x = btn_x & ~btn_x_q. A level held high produces exactly one press.
- **IDLE:**
  - The ball is at the server's end: pos 0 for L, N_LEDS-1 for R.
  - A press by the server moves to MOVE_R (left server) or MOVE_L (right server).
  - The non-server's button and tick are ignored.
- **MOVE_R:**
  - The hit window is pos == N_LEDS-1.
  - press_r while pos == N_LEDS-1 is a hit: go to MOVE_L, pos unchanged.
  - press_r while pos < N_LEDS-1 is an early swing: the left player scores.
  - tick while pos < N_LEDS-1 increments pos.
  - tick while pos == N_LEDS-1 with no press_r is a miss: the left player scores.
  - If press_r and tick coincide at pos == N_LEDS-1, the hit wins.
  - btn_l is ignored.
- **MOVE_L:** mirror image of MOVE_R (window pos == 0, decrements pos, right player scores on a fault).
- **Scoring:**
  - The scorer's score increments by 1 and point pulses for one cycle.
  - If the new score equals WIN_SCORE, go to OVER.
  - Otherwise go to POINT, clear hold, and set serve_side to the player who lost the point.
  - Scores never wrap.
- **POINT:**
  - hold increments on each tick.
  - On the tick where hold reaches POINT_TICKS-1, go to IDLE with pos set to serve_side's end.
  - Buttons are ignored.
- **OVER:**
  - Scores are frozen.
  - btn_l & btn_r both high in the same cycle restarts the game: scores cleared, serve_side = L, pos = 0, IDLE.
- **leds:**
  - IDLE/MOVE_x: one-hot at pos.
  - POINT: all ones.
  - OVER: lower half ones if the left player won, upper half ones if the right player won.

## Timing
- All state and outputs are registered; a decision made at clock edge k is visible on the outputs after edge k.
- A button first sampled high at edge k (low at k-1) acts at edge k.
- The ball advances exactly one position per tick cycle.
- No pipelining and no latency beyond one register stage.
- **Reset (asynchronous, while low):**
  - state IDLE, pos 0, serve_side L.
  - leds = 1, score_l = score_r = 0, point = 0, game_over = 0.
  - hold = 0, btn_l_q = btn_r_q = 0.
- **Reset mid-rally:** all registers take reset values immediately.
- **Button held through reset release:** btn_x_q clears on reset, so the first clock edge after release with the button high registers a press.

## Test plan
- **Serve and rally (N_LEDS=8, POINT_TICKS=2):** reset, pulse btn_l → MOVE_R. 7 ticks → leds = 0x80. press_r → MOVE_L. Next tick → leds = 0x40.
- **Miss:** in MOVE_R at pos 7, tick with no press → score_l = 1 and point pulses for one cycle. leds = 0xFF for 2 ticks, then IDLE with leds = 0x80 (right serves).
- **Early swing:** in MOVE_R at pos 3, press_r → score_l increments. In MOVE_L, press_l at pos 5 → score_r increments.
- **Simultaneous hit and tick:** at pos 7, tick and press_r in the same cycle → MOVE_L, no score change. btn_r held high for 10 cycles → exactly one press.
- **Win (WIN_SCORE=3):** three misses by the right player → score_l = 3, game_over = 1, leds = 0x0F. Ticks and single buttons ignored. Both buttons high together → scores 0, leds = 0x01, IDLE.
- **Reset mid-rally:** assert reset asynchronously between edges at pos 4 → outputs at reset values before the next edge. After release, pressing btn_r alone has no effect because left serves.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// rtl/pong_ball_ctrl.sv - ping-pong ball/rally controller: ball motion, paddle hits, scoring, game over
// The ball steps one LED per tick; scores, leds, point and game_over are all registered.
module pong_ball_ctrl #(
  parameter int N_LEDS      = 8,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int POINT_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                btn_l,
  input  logic                btn_r,
  output logic [N_LEDS-1:0]   leds,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                point,
  output logic                game_over
);

  localparam int POS_W  = $clog2(N_LEDS);
  localparam int HOLD_W = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;
  localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(N_LEDS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(POINT_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [N_LEDS-1:0]  LED_ONE  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0]  LED_LOW  = {{(N_LEDS - N_LEDS/2){1'b0}}, {(N_LEDS/2){1'b1}}};

  typedef enum logic [2:0] {ST_IDLE, ST_MOVE_R, ST_MOVE_L, ST_POINT, ST_OVER} state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                serve_q, serve_d;   // 0: left serves, 1: right serves
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic                btn_l_q, btn_r_q;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                point_q, point_d;
  logic                game_over_q, game_over_d;

  logic press_l, press_r;
  logic score_left, score_right;

  assign press_l = btn_l & ~btn_l_q;
  assign press_r = btn_r & ~btn_r_q;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    serve_d     = serve_q;
    hold_d      = hold_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_d     = 1'b0;
    score_left  = 1'b0;
    score_right = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!serve_q && press_l)     state_d = ST_MOVE_R;
        else if (serve_q && press_r) state_d = ST_MOVE_L;
      end
      ST_MOVE_R: begin
        // A press in the window beats a coincident tick.
        if (press_r) begin
          if (pos_q == POS_MAX) state_d = ST_MOVE_L;
          else                  score_left = 1'b1;
        end else if (tick) begin
          if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
          else                  score_left = 1'b1;
        end
      end
      ST_MOVE_L: begin
        if (press_l) begin
          if (pos_q == '0) state_d = ST_MOVE_R;
          else             score_right = 1'b1;
        end else if (tick) begin
          if (pos_q != '0) pos_d = pos_q - 1'b1;
          else             score_right = 1'b1;
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (hold_q == HOLD_MAX) begin
            state_d = ST_IDLE;
            pos_d   = serve_q ? POS_MAX : '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (btn_l && btn_r) begin
          state_d   = ST_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          serve_d   = 1'b0;
          pos_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (score_left) begin
      if (score_l_q != '1) score_l_d = score_l_q + 1'b1;
      point_d = 1'b1;
      if (score_l_d == WIN) begin
        state_d = ST_OVER;
      end else begin
        state_d = ST_POINT;
        hold_d  = '0;
        serve_d = 1'b1;
      end
    end
    if (score_right) begin
      if (score_r_q != '1) score_r_d = score_r_q + 1'b1;
      point_d = 1'b1;
      if (score_r_d == WIN) begin
        state_d = ST_OVER;
      end else begin
        state_d = ST_POINT;
        hold_d  = '0;
        serve_d = 1'b0;
      end
    end

    case (state_d)
      ST_POINT: leds_d = '1;
      ST_OVER:  leds_d = (score_l_d == WIN) ? LED_LOW : ~LED_LOW;
      default:  leds_d = LED_ONE << pos_d;
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      serve_q     <= 1'b0;
      hold_q      <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      btn_l_q     <= 1'b0;
      btn_r_q     <= 1'b0;
      leds_q      <= LED_ONE;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      serve_q     <= serve_d;
      hold_q      <= hold_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      btn_l_q     <= btn_l;
      btn_r_q     <= btn_r;
      leds_q      <= leds_d;
      point_q     <= point_d;
      game_over_q <= game_over_d;
    end
  end

  assign leds      = leds_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point     = point_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb/tb_pong_ball_ctrl.sv - directed self-checking bench for pong_ball_ctrl
// Runs with N_LEDS=8, SCORE_W=4, WIN_SCORE=3, POINT_TICKS=2; inputs change 1ns after each rising edge.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_l;
  logic       btn_r;
  logic [7:0] leds;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  pong_ball_ctrl #(
    .N_LEDS(8), .SCORE_W(4), .WIN_SCORE(3), .POINT_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_l(btn_l), .btn_r(btn_r),
    .leds(leds), .score_l(score_l), .score_r(score_r),
    .point(point), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic bl, input logic br);
    tick  = t;
    btn_l = bl;
    btn_r = br;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick  = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Right serves from pos 7, ball travels to pos 0, left hits, right swings early at pos 0.
  task automatic right_early_swing_point();
    cyc(1'b0, 1'b0, 1'b1);
    ticks(7);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick = 1'b0; btn_l = 1'b0; btn_r = 1'b0; reset = 1'b0;
    #12;
    check_eq("rst_leds", leds, 8'h01);
    check_eq("rst_score_l", score_l, 4'd0);
    check_eq("rst_score_r", score_r, 4'd0);
    check_eq("rst_point", point, 1'b0);
    check_eq("rst_game_over", game_over, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Serve and rally
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("idle_tick_ignored", leds, 8'h01);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("serve_leds", leds, 8'h01);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("rally_pos3", leds, 8'h08);
    ticks(4);
    check_eq("rally_pos7", leds, 8'h80);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("hit_leds", leds, 8'h80);
    check_eq("hit_no_point", point, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("return_pos6", leds, 8'h40);
    check_eq("rally_score_l", score_l, 4'd0);

    // Miss by right player
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    ticks(7);
    ticks(1);
    check_eq("miss_score_l", score_l, 4'd1);
    check_eq("miss_point", point, 1'b1);
    check_eq("miss_leds", leds, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("miss_point_drop", point, 1'b0);
    ticks(1);
    check_eq("hold_tick1", leds, 8'hFF);
    ticks(1);
    check_eq("serve_r_leds", leds, 8'h80);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("non_server_ignored", leds, 8'h80);

    // Right serves, left swings early at pos 5
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("serve_r_move", leds, 8'h40);
    ticks(1);
    check_eq("move_l_pos5", leds, 8'h20);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("early_l_score_r", score_r, 4'd1);
    check_eq("early_l_point", point, 1'b1);
    ticks(2);
    check_eq("serve_l_after_r", leds, 8'h01);

    // Left serves, right swings early at pos 3
    cyc(1'b0, 1'b1, 1'b0);
    ticks(3);
    check_eq("move_r_pos3", leds, 8'h08);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("early_r_score_l", score_l, 4'd2);
    check_eq("early_r_score_r", score_r, 4'd1);
    check_eq("early_r_leds", leds, 8'hFF);

    // Simultaneous hit and tick
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    ticks(7);
    cyc(1'b1, 1'b0, 1'b1);
    check_eq("sim_hit_leds", leds, 8'h80);
    check_eq("sim_hit_score", score_l, 4'd0);
    cyc(1'b1, 1'b0, 1'b1);
    check_eq("sim_hit_moves_l", leds, 8'h40);

    // btn_r held high: no repeated presses while the ball travels right
    do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1);
    check_eq("held_no_swing_leds", leds, 8'h80);
    check_eq("held_no_swing_score", score_l, 4'd0);
    cyc(1'b1, 1'b0, 1'b1);
    check_eq("held_then_miss", score_l, 4'd1);

    // Win at 3: right player loses three points
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    ticks(8);
    ticks(2);
    right_early_swing_point();
    check_eq("win_score2", score_l, 4'd2);
    ticks(2);
    check_eq("win_serve_r", leds, 8'h80);
    right_early_swing_point();
    check_eq("win_score3", score_l, 4'd3);
    check_eq("win_game_over", game_over, 1'b1);
    check_eq("win_leds", leds, 8'h0F);
    check_eq("win_point", point, 1'b1);
    ticks(3);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("over_frozen_score", score_l, 4'd3);
    check_eq("over_frozen_leds", leds, 8'h0F);
    check_eq("over_point_low", point, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check_eq("restart_score_l", score_l, 4'd0);
    check_eq("restart_leds", leds, 8'h01);
    check_eq("restart_game_over", game_over, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("restart_left_serves", leds, 8'h02);

    // Right player wins: upper half lit
    do_reset();
    for (int p = 0; p < 3; p++) begin
      cyc(1'b0, 1'b1, 1'b0);
      ticks(7);
      cyc(1'b0, 1'b0, 1'b1);
      ticks(7);
      ticks(1);
      if (p < 2) ticks(2);
    end
    check_eq("r_win_score_r", score_r, 4'd3);
    check_eq("r_win_leds", leds, 8'hF0);

    // Asynchronous reset mid-rally
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    ticks(4);
    check_eq("pre_reset_pos4", leds, 8'h10);
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_rst_leds", leds, 8'h01);
    check_eq("async_rst_go", game_over, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("post_rst_btn_r_ignored", leds, 8'h01);

    // btn_l held through reset release registers one press
    tick = 1'b0; btn_r = 1'b0; btn_l = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check_eq("held_through_reset", leds, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
